// File: rtl/tod_counter_if.sv
// Load handshake bundle for tod_counter: the time source drives valid/time, the counter
// answers with ready and a one-cycle error pulse for rejected values.
interface tod_counter_if;
  logic        load_valid;
  logic        load_ready;
  logic [23:0] load_time;
  logic        load_err;

  modport master (
    output load_valid,
    output load_time,
    input  load_ready,
    input  load_err
  );

  modport slave (
    input  load_valid,
    input  load_time,
    output load_ready,
    output load_err
  );
endinterface

// File: rtl/tod_counter.sv
// BCD time-of-day counter: prescaled second tick, 12/24-hour format, edge-detected set
// buttons with pending counts, validated load. Alarm compiled in with `define TOD_ALARM_EN.
module tod_counter #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned DIV_W    = 27,
  parameter bit          MODE_12H = 1'b0
) (
  input  logic         CLK100MHZ,
  input  logic         RESET_BTN,
  input  logic         inc_min,
  input  logic         inc_hour,
  tod_counter_if.slave load_if,
  output logic [3:0]   hours2,
  output logic [3:0]   hours1,
  output logic [3:0]   mins2,
  output logic [3:0]   mins1,
  output logic [3:0]   secs2,
  output logic [3:0]   secs1,
  output logic         pm,
  output logic         sec_tick,
  output logic         day_wrap
`ifdef TOD_ALARM_EN
  ,
  input  logic         alarm_set,
  input  logic [15:0]  alarm_time,
  input  logic         alarm_clr,
  output logic         alarm
`endif
);

  localparam logic [3:0] RstH2 = MODE_12H ? 4'd1 : 4'd0;
  localparam logic [3:0] RstH1 = MODE_12H ? 4'd2 : 4'd0;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0] h2_q, h2_d, h1_q, h1_d, m2_q, m2_d, m1_q, m1_d, s2_q, s2_d, s1_q, s1_d;
  logic       pm_q, pm_d;
  logic       sec_tick_q, sec_tick_d, day_wrap_q, day_wrap_d, load_err_q, load_err_d;
  logic       min_prev_q, hour_prev_q;
  logic [1:0] pend_min_q, pend_min_d, pend_hour_q, pend_hour_d;
  logic [1:0] min_tot, hour_tot;
  logic       tick, load_go, load_ok;
  logic [3:0] ld_h2;
  logic       ld_pm;
  logic [8:0] hour_next;
  logic       hour_wrap;

  function automatic logic hours_ok(input logic [3:0] h2, input logic [3:0] h1);
    if (h1 > 4'd9) return 1'b0;
    if (MODE_12H) return (h2 == 4'd0 && h1 != 4'd0) || (h2 == 4'd1 && h1 <= 4'd2);
    return (h2 < 4'd2) || (h2 == 4'd2 && h1 <= 4'd3);
  endfunction

  // Returns {pm, h2, h1} after one hour step in the configured format.
  function automatic logic [8:0] hour_inc(input logic [3:0] h2, input logic [3:0] h1,
                                          input logic p);
    logic [8:0] r;
    r = {p, h2, h1 + 4'd1};
    if (MODE_12H) begin
      if (h2 == 4'd1 && h1 == 4'd2)      r = {p, 4'd0, 4'd1};
      else if (h2 == 4'd1 && h1 == 4'd1) r = {~p, 4'd1, 4'd2};
      else if (h1 == 4'd9)               r = {p, 4'd1, 4'd0};
    end else begin
      if (h2 == 4'd2 && h1 == 4'd3)      r = {p, 4'd0, 4'd0};
      else if (h1 == 4'd9)               r = {p, h2 + 4'd1, 4'd0};
    end
    return r;
  endfunction

  assign tick      = (cnt_q == DIV_W'(TICK_DIV - 1));
  assign min_tot   = pend_min_q + {1'b0, inc_min & ~min_prev_q};
  assign hour_tot  = pend_hour_q + {1'b0, inc_hour & ~hour_prev_q};
  assign hour_next = hour_inc(h2_q, h1_q, pm_q);
  assign hour_wrap = MODE_12H ? (h2_q == 4'd1 && h1_q == 4'd1 && pm_q)
                              : (h2_q == 4'd2 && h1_q == 4'd3);

  assign ld_h2   = MODE_12H ? {1'b0, load_if.load_time[22:20]} : load_if.load_time[23:20];
  assign ld_pm   = MODE_12H & load_if.load_time[23];
  assign load_ok = hours_ok(ld_h2, load_if.load_time[19:16]) &&
                   load_if.load_time[15:12] <= 4'd5 && load_if.load_time[11:8] <= 4'd9 &&
                   load_if.load_time[7:4] <= 4'd5 && load_if.load_time[3:0] <= 4'd9;

  assign load_if.load_ready = ~tick && pend_min_q == 2'd0 && pend_hour_q == 2'd0;
  assign load_go            = load_if.load_valid & load_if.load_ready;

  always_comb begin
    cnt_d       = cnt_q + DIV_W'(1);
    h2_d        = h2_q;
    h1_d        = h1_q;
    m2_d        = m2_q;
    m1_d        = m1_q;
    s2_d        = s2_q;
    s1_d        = s1_q;
    pm_d        = pm_q;
    sec_tick_d  = 1'b0;
    day_wrap_d  = 1'b0;
    load_err_d  = 1'b0;
    pend_min_d  = min_tot;
    pend_hour_d = hour_tot;

    if (load_go) begin
      if (load_ok) begin
        {h2_d, h1_d}         = {ld_h2, load_if.load_time[19:16]};
        {m2_d, m1_d}         = load_if.load_time[15:8];
        {s2_d, s1_d}         = load_if.load_time[7:0];
        pm_d                 = ld_pm;
        cnt_d                = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      cnt_d      = '0;
      sec_tick_d = 1'b1;
      if (s1_q != 4'd9) s1_d = s1_q + 4'd1;
      else begin
        s1_d = 4'd0;
        if (s2_q != 4'd5) s2_d = s2_q + 4'd1;
        else begin
          s2_d = 4'd0;
          if (m1_q != 4'd9) m1_d = m1_q + 4'd1;
          else begin
            m1_d = 4'd0;
            if (m2_q != 4'd5) m2_d = m2_q + 4'd1;
            else begin
              m2_d               = 4'd0;
              {pm_d, h2_d, h1_d} = hour_next;
              day_wrap_d         = hour_wrap;
            end
          end
        end
      end
    end else if (min_tot != 2'd0) begin
      // Minutes win over hours; the hour request stays counted for a later cycle.
      pend_min_d = min_tot - 2'd1;
      if (m1_q != 4'd9) m1_d = m1_q + 4'd1;
      else begin
        m1_d = 4'd0;
        m2_d = (m2_q == 4'd5) ? 4'd0 : m2_q + 4'd1;
      end
    end else if (hour_tot != 2'd0) begin
      pend_hour_d        = hour_tot - 2'd1;
      {pm_d, h2_d, h1_d} = hour_next;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET_BTN) begin
      cnt_q       <= '0;
      h2_q        <= RstH2;
      h1_q        <= RstH1;
      m2_q        <= 4'd0;
      m1_q        <= 4'd0;
      s2_q        <= 4'd0;
      s1_q        <= 4'd0;
      pm_q        <= 1'b0;
      sec_tick_q  <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
      min_prev_q  <= 1'b0;
      hour_prev_q <= 1'b0;
      pend_min_q  <= 2'd0;
      pend_hour_q <= 2'd0;
    end else begin
      cnt_q       <= cnt_d;
      h2_q        <= h2_d;
      h1_q        <= h1_d;
      m2_q        <= m2_d;
      m1_q        <= m1_d;
      s2_q        <= s2_d;
      s1_q        <= s1_d;
      pm_q        <= pm_d;
      sec_tick_q  <= sec_tick_d;
      day_wrap_q  <= day_wrap_d;
      load_err_q  <= load_err_d;
      min_prev_q  <= inc_min;
      hour_prev_q <= inc_hour;
      pend_min_q  <= pend_min_d;
      pend_hour_q <= pend_hour_d;
    end
  end

  assign hours2           = h2_q;
  assign hours1           = h1_q;
  assign mins2            = m2_q;
  assign mins1            = m1_q;
  assign secs2            = s2_q;
  assign secs1            = s1_q;
  assign pm               = pm_q;
  assign sec_tick         = sec_tick_q;
  assign day_wrap         = day_wrap_q;
  assign load_if.load_err = load_err_q;

`ifdef TOD_ALARM_EN
  logic [16:0] al_q;
  logic        armed_q, alarm_q, al_ok, alarm_hit;
  logic [3:0]  al_h2;
  logic        al_pm;

  assign al_h2 = MODE_12H ? {1'b0, alarm_time[14:12]} : alarm_time[15:12];
  assign al_pm = MODE_12H & alarm_time[15];
  assign al_ok = hours_ok(al_h2, alarm_time[11:8]) &&
                 alarm_time[7:4] <= 4'd5 && alarm_time[3:0] <= 4'd9;
  // Only the tick path can raise the alarm; button steps never match.
  assign alarm_hit = tick && armed_q && s2_d == 4'd0 && s1_d == 4'd0 &&
                     {pm_d, h2_d, h1_d, m2_d, m1_d} == al_q;

  always_ff @(posedge CLK100MHZ) begin
    if (RESET_BTN) begin
      al_q    <= '0;
      armed_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      if (alarm_set && al_ok) begin
        al_q    <= {al_pm, al_h2, alarm_time[11:0]};
        armed_q <= 1'b1;
      end
      if (alarm_hit)      alarm_q <= 1'b1;
      else if (alarm_clr) alarm_q <= 1'b0;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Bench for tod_counter: a 24h and a 12h instance share random stimulus and are checked
// every cycle against a seconds-of-day model, plus directed scenarios with literal results.
module tb_tod_counter;
  localparam int unsigned TD = 4;
  localparam int unsigned DW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, inc_min, inc_hour, load_valid;
  logic [23:0] load_time;
  logic [23:0] dig24, dig12;
  logic        pm24, pm12, st24, st12, dw24, dw12;
  int          n_vec = 0, n_bad = 0;

  tod_counter_if if24 ();
  tod_counter_if if12 ();
  assign if24.load_valid = load_valid;
  assign if24.load_time  = load_time;
  assign if12.load_valid = load_valid;
  assign if12.load_time  = load_time;

`ifdef TOD_ALARM_EN
  logic alarm24, alarm12;
`endif

  tod_counter #(.TICK_DIV(TD), .DIV_W(DW), .MODE_12H(1'b0)) u_dut24 (
    .CLK100MHZ(clk), .RESET_BTN(rst), .inc_min(inc_min), .inc_hour(inc_hour),
    .load_if(if24.slave),
    .hours2(dig24[23:20]), .hours1(dig24[19:16]), .mins2(dig24[15:12]),
    .mins1(dig24[11:8]), .secs2(dig24[7:4]), .secs1(dig24[3:0]),
    .pm(pm24), .sec_tick(st24), .day_wrap(dw24)
`ifdef TOD_ALARM_EN
    , .alarm_set(1'b0), .alarm_time(16'h0000), .alarm_clr(1'b0), .alarm(alarm24)
`endif
  );

  tod_counter #(.TICK_DIV(TD), .DIV_W(DW), .MODE_12H(1'b1)) u_dut12 (
    .CLK100MHZ(clk), .RESET_BTN(rst), .inc_min(inc_min), .inc_hour(inc_hour),
    .load_if(if12.slave),
    .hours2(dig12[23:20]), .hours1(dig12[19:16]), .mins2(dig12[15:12]),
    .mins1(dig12[11:8]), .secs2(dig12[7:4]), .secs1(dig12[3:0]),
    .pm(pm12), .sec_tick(st12), .day_wrap(dw12)
`ifdef TOD_ALARM_EN
    , .alarm_set(1'b0), .alarm_time(16'h0000), .alarm_clr(1'b0), .alarm(alarm12)
`endif
  );

  // Model: time as seconds since midnight, pending button steps as plain counts.
  int m_t[2], m_cnt[2], m_pm[2], m_ph[2];
  bit m_st[2], m_dw[2], m_err[2];
  bit prev_min, prev_hour, m_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic bit load_ok(input logic [23:0] lt, input bit mode12, output int secs);
    int h2, h1, m2, m1, s2, s1, hd, h24;
    bit ok;
    h1 = int'(lt[19:16]); m2 = int'(lt[15:12]); m1 = int'(lt[11:8]);
    s2 = int'(lt[7:4]);   s1 = int'(lt[3:0]);
    if (mode12) begin
      h2  = int'(lt[22:20]);
      hd  = h2 * 10 + h1;
      ok  = (h1 <= 9) && hd >= 1 && hd <= 12;
      h24 = (hd % 12) + (lt[23] ? 12 : 0);
    end else begin
      h2  = int'(lt[23:20]);
      hd  = h2 * 10 + h1;
      ok  = (h1 <= 9) && hd <= 23;
      h24 = hd;
    end
    ok   = ok && m2 <= 5 && m1 <= 9 && s2 <= 5 && s1 <= 9;
    secs = h24 * 3600 + (m2 * 10 + m1) * 60 + s2 * 10 + s1;
    return ok;
  endfunction

  function automatic logic [23:0] exp_dig(input int t, input bit mode12);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    if (mode12) h = (h % 12 == 0) ? 12 : h % 12;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit m_rdy(input int i);
    return m_cnt[i] != int'(TD - 1) && m_pm[i] == 0 && m_ph[i] == 0;
  endfunction

  always @(posedge clk) begin : model
    bit me, he, tk, rdy;
    int ns, h, m, s;
    me = inc_min && !prev_min;
    he = inc_hour && !prev_hour;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_t[i] = 0; m_cnt[i] = 0; m_pm[i] = 0; m_ph[i] = 0;
        m_st[i] = 0; m_dw[i] = 0; m_err[i] = 0;
      end else begin
        tk  = (m_cnt[i] == int'(TD - 1));
        rdy = m_rdy(i);
        m_pm[i] += int'(me);
        m_ph[i] += int'(he);
        m_st[i] = 0; m_dw[i] = 0; m_err[i] = 0;
        h = m_t[i] / 3600; m = (m_t[i] / 60) % 60; s = m_t[i] % 60;
        if (load_valid && rdy) begin
          if (load_ok(load_time, i == 1, ns)) begin
            m_t[i] = ns; m_cnt[i] = 0;
          end else begin
            m_err[i] = 1; m_cnt[i]++;
          end
        end else if (tk) begin
          m_t[i] = (m_t[i] + 1) % 86400;
          m_st[i] = 1; m_dw[i] = (m_t[i] == 0); m_cnt[i] = 0;
        end else begin
          m_cnt[i]++;
          if (m_pm[i] > 0) begin
            m_pm[i]--; m_t[i] = h * 3600 + ((m + 1) % 60) * 60 + s;
          end else if (m_ph[i] > 0) begin
            m_ph[i]--; m_t[i] = ((h + 1) % 24) * 3600 + m * 60 + s;
          end
        end
      end
    end
    prev_min  = rst ? 1'b0 : inc_min;
    prev_hour = rst ? 1'b0 : inc_hour;
    m_on      = 1'b1;
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("dig24", dig24, exp_dig(m_t[0], 1'b0));
      chk("dig12", dig12, exp_dig(m_t[1], 1'b1));
      chk("pm24", pm24, 1'b0);
      chk("pm12", pm12, m_t[1] >= 43200);
      chk("sec_tick24", st24, m_st[0]);
      chk("sec_tick12", st12, m_st[1]);
      chk("day_wrap24", dw24, m_dw[0]);
      chk("day_wrap12", dw12, m_dw[1]);
      chk("load_err24", if24.load_err, m_err[0]);
      chk("load_err12", if12.load_err, m_err[1]);
      chk("load_ready24", if24.load_ready, m_rdy(0));
      chk("load_ready12", if12.load_ready, m_rdy(1));
    end
  end

  int st_cnt, dw_cnt;
  always @(negedge clk) begin
    if (st24) st_cnt++;
    if (dw24) dw_cnt++;
  end

  task automatic load_pulse(input logic [23:0] lt, input int idx);
    bit ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (m_rdy(idx)) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) timeout("load_wait");
    load_valid = 1'b1;
    load_time  = lt;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_tick_cycle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (m_cnt[0] == int'(TD - 1) && m_pm[0] == 0 && m_ph[0] == 0) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) timeout(name);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [23:0] rand_time();
    int h, m, s;
    logic [23:0] r;
    m = $urandom_range(0, 59);
    s = $urandom_range(0, 59);
    case ($urandom_range(0, 2))
      0: r = 24'($urandom());
      1: begin
        h = $urandom_range(0, 23);
        r = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
      end
      default: begin
        h = $urandom_range(1, 12);
        r = {1'($urandom_range(0, 1)), 3'(h / 10), 4'(h % 10),
             4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
      end
    endcase
    return r;
  endfunction

  initial begin
    rst = 1'b1; inc_min = 1'b0; inc_hour = 1'b0; load_valid = 1'b0; load_time = '0;
    repeat (3) @(posedge clk);
    settle(1);
    chk("reset_dig24", dig24, 24'h000000);
    chk("reset_dig12", dig12, 24'h120000);
    chk("reset_pm12", pm12, 1'b0);
    rst = 1'b0;
    st_cnt = 0;

    // 240 cycles of free running: 60 ticks
    repeat (240) @(posedge clk);
    settle(1);
    chk("run240_dig24", dig24, 24'h000100);
    chk("run240_dig12", dig12, 24'h120100);
    chk("run240_ticks", st_cnt, 60);

    // 23:59:58 + two ticks wraps to midnight with a single day_wrap
    load_pulse(24'h235958, 0);
    dw_cnt = 0;
    settle(9);
    chk("midnight_dig24", dig24, 24'h000000);
    chk("midnight_wraps", dw_cnt, 1);

    // 11:59:59 AM + one tick -> 12:00:00 PM
    load_pulse(24'h115959, 1);
    settle(5);
    chk("noon_dig12", dig12, 24'h120000);
    chk("noon_pm12", pm12, 1'b1);
    chk("noon_dig24", dig24, 24'h120000);

    // Minute button rising on the tick cycle at 00:00:59
    load_pulse(24'h000059, 0);
    wait_tick_cycle("tick_wait_min");
    inc_min = 1'b1;
    settle(1);
    chk("collide_tick", dig24, 24'h000100);
    settle(1);
    chk("collide_min", dig24, 24'h000200);
    inc_min = 1'b0;

    // Held hour button at 23:xx: one step to 00:xx, no day_wrap
    load_pulse(24'h231000, 0);
    inc_hour = 1'b1;
    dw_cnt = 0;
    settle(50);
    inc_hour = 1'b0;
    chk("hold_hour_hm", dig24[23:8], 16'h0010);
    chk("hold_hour_wraps", dw_cnt, 0);

    // Invalid minutes are rejected with an error pulse
    load_pulse(24'h126700, 0);
    settle(1);
    chk("bad_load_err24", if24.load_err, 1'b1);
    chk("bad_load_err12", if12.load_err, 1'b1);
    chk("bad_load_hm", dig24[23:8], 16'h0010);

    // Load offered in a tick cycle completes on the next cycle
    wait_tick_cycle("tick_wait_load");
    load_valid = 1'b1;
    load_time  = 24'h081530;
    chk("tick_ready", if24.load_ready, 1'b0);
    @(posedge clk); #1;
    chk("after_tick_ready", if24.load_ready, 1'b1);
    @(posedge clk); #1;
    load_valid = 1'b0;
    settle(1);
    chk("tick_load_dig24", dig24, 24'h081530);
    chk("tick_load_dig12", dig12, 24'h081530);

    // Randomised traffic, including occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 3) == 0) inc_min = ~inc_min;
      if ($urandom_range(0, 5) == 0) inc_hour = ~inc_hour;
      load_valid = ($urandom_range(0, 11) == 0);
      load_time  = rand_time();
      rst        = ($urandom_range(0, 399) == 0);
    end
    load_valid = 1'b0;
    inc_min = 1'b0;
    inc_hour = 1'b0;
    rst = 1'b0;

    // Reset mid-count returns to reset values
    settle(7);
    rst = 1'b1;
    settle(1);
    chk("midreset_dig24", dig24, 24'h000000);
    chk("midreset_dig12", dig12, 24'h120000);
    chk("midreset_tick", st24, 1'b0);
    rst = 1'b0;
    settle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
